// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush controller for the 5-stage core.
// Resolves load-use, branch mispredict, memory wait and MUL/DIV hazards into
// per-stage stall/flush controls and keeps saturating performance counters.
module pipeline_hazard_ctrl #(
  parameter int MD_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  exe_rd,
  input  logic        exe_is_load,
  input  logic        exe_br_valid,
  input  logic        exe_br_taken,
  input  logic        exe_BP_taken,
  input  logic        exe_md_start,
  input  logic        im_busy,
  input  logic        dm_busy,
  input  logic        cnt_clr,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_exe,
  output logic        stall_mem,
  output logic        flush_id,
  output logic        flush_exe,
  output logic        flush_mem,
  output logic        pc_redirect,
  output logic        md_done,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  md_state_e   state_q, state_d;
  logic [7:0]  md_cnt_q, md_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic mispredict;
  logic load_use;
  logic md_stall;
  logic any_stall;
  logic flush_win;

  // Hazard detection terms shared by the priority logic and the FSM
  always_comb begin
    mispredict = exe_br_valid && (exe_br_taken != exe_BP_taken);
    load_use   = exe_is_load && (exe_rd != 5'd0) &&
                 ((id_use_rs1 && (id_rs1 == exe_rd)) ||
                  (id_use_rs2 && (id_rs2 == exe_rd)));
    md_stall   = ((state_q == IDLE) && exe_md_start) || (state_q == BUSY);
  end

  // Priority encoder: the first matching hazard alone drives stall/flush/redirect
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_exe   = 1'b0;
    stall_mem   = 1'b0;
    flush_id    = 1'b0;
    flush_exe   = 1'b0;
    flush_mem   = 1'b0;
    pc_redirect = 1'b0;
    flush_win   = 1'b0;
    if (dm_busy) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_exe = 1'b1;
      stall_mem = 1'b1;
    end else if (mispredict) begin
      flush_id    = 1'b1;
      flush_exe   = 1'b1;
      pc_redirect = 1'b1;
      flush_win   = 1'b1;
    end else if (md_stall) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_exe = 1'b1;
      flush_mem = 1'b1;
    end else if (load_use) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      flush_exe = 1'b1;
    end else if (im_busy) begin
      stall_if = 1'b1;
      flush_id = 1'b1;
    end
    any_stall = stall_if || stall_id || stall_exe || stall_mem;
  end

  // MUL/DIV sequencer: count runs regardless of dm_busy, DONE waits for dm release
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (exe_md_start && !dm_busy && !mispredict) begin
          state_d  = BUSY;
          md_cnt_d = 8'(MD_LAT - 1);
        end
      end
      BUSY: begin
        if (md_cnt_q == 8'd0) begin
          state_d = DONE;
        end else begin
          md_cnt_d = md_cnt_q - 8'd1;
        end
      end
      DONE: begin
        if (!dm_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    md_done = (state_q == DONE);
  end

  // Saturating performance counters, clear wins over increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = 32'd0;
      flush_cnt_d = 32'd0;
    end else begin
      if (any_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (flush_win && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_d = flush_cnt_q + 32'd1;
      end
    end
    stall_cnt = stall_cnt_q;
    flush_cnt = flush_cnt_q;
  end

  // State and counter registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      md_cnt_q    <= 8'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl with MD_LAT = 4.
module tb_pipeline_hazard_ctrl;
  localparam int MD_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, exe_rd;
  logic        id_use_rs1, id_use_rs2, exe_is_load;
  logic        exe_br_valid, exe_br_taken, exe_BP_taken, exe_md_start;
  logic        im_busy, dm_busy, cnt_clr;
  logic        stall_if, stall_id, stall_exe, stall_mem;
  logic        flush_id, flush_exe, flush_mem, pc_redirect, md_done;
  logic [31:0] stall_cnt, flush_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_LAT(MD_LAT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .exe_rd(exe_rd), .exe_is_load(exe_is_load),
    .exe_br_valid(exe_br_valid), .exe_br_taken(exe_br_taken),
    .exe_BP_taken(exe_BP_taken), .exe_md_start(exe_md_start),
    .im_busy(im_busy), .dm_busy(dm_busy), .cnt_clr(cnt_clr),
    .stall_if(stall_if), .stall_id(stall_id),
    .stall_exe(stall_exe), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_exe(flush_exe), .flush_mem(flush_mem),
    .pc_redirect(pc_redirect), .md_done(md_done),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       load;
    logic       brv;
    logic       brt;
    logic       bpt;
    logic       im;
    logic       dm;
    logic [3:0] exp_stall;
    logic [2:0] exp_flush;
    logic       exp_redir;
  } vec_t;

  vec_t vecs[13];

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Compares {stall_if,id,exe,mem, flush_id,exe,mem, pc_redirect, md_done}
  task automatic checkOutput(input string name, input logic [3:0] es, input logic [2:0] ef,
                             input logic er, input logic ed);
    logic [8:0] act;
    logic [8:0] exp;
    act = {stall_if, stall_id, stall_exe, stall_mem, flush_id, flush_exe, flush_mem,
           pc_redirect, md_done};
    exp = {es, ef, er, ed};
    checkValue(name, {23'd0, act}, {23'd0, exp});
  endtask

  task automatic clearInputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    exe_rd = 5'd0; exe_is_load = 1'b0; exe_br_valid = 1'b0; exe_br_taken = 1'b0;
    exe_BP_taken = 1'b0; exe_md_start = 1'b0; im_busy = 1'b0; dm_busy = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    clearInputs();
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.use1; id_use_rs2 = v.use2;
    exe_rd = v.rd; exe_is_load = v.load; exe_br_valid = v.brv;
    exe_br_taken = v.brt; exe_BP_taken = v.bpt; im_busy = v.im; dm_busy = v.dm;
    #1;
  endtask

  initial begin
    //            rs1   rs2   u1 u2 rd    ld br bt bp im dm  stall    flush   rd
    vecs[0]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 0};
    vecs[1]  = '{5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, 0, 0, 4'b1100, 3'b010, 0};
    vecs[2]  = '{5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 0};
    vecs[3]  = '{5'd3, 5'd7, 0, 1, 5'd7, 1, 0, 0, 0, 0, 0, 4'b1100, 3'b010, 0};
    vecs[4]  = '{5'd5, 5'd0, 0, 0, 5'd5, 1, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 0};
    vecs[5]  = '{5'd5, 5'd0, 1, 0, 5'd5, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 0};
    vecs[6]  = '{5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1, 0, 1, 0, 4'b0000, 3'b110, 1};
    vecs[7]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1, 0, 0, 4'b0000, 3'b000, 0};
    vecs[8]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1, 0, 0, 4'b0000, 3'b110, 1};
    vecs[9]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 0, 4'b1000, 3'b100, 0};
    vecs[10] = '{5'd9, 5'd0, 1, 0, 5'd9, 1, 0, 0, 0, 1, 0, 4'b1100, 3'b010, 0};
    vecs[11] = '{5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1, 0, 1, 1, 4'b1111, 3'b000, 0};
    vecs[12] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, 0, 4'b0000, 3'b000, 0};

    // Reset state
    clearInputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checkOutput("reset_outputs", 4'b0000, 3'b000, 1'b0, 1'b0);
    checkValue("reset_stall_cnt", stall_cnt, 32'd0);
    checkValue("reset_flush_cnt", flush_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Combinational priority vectors
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp_flush,
                  vecs[i].exp_redir, 1'b0);
    end
    @(negedge clk);
    clearInputs();
    #1;
    checkValue("table_stall_cnt", stall_cnt, 32'd5);
    checkValue("table_flush_cnt", flush_cnt, 32'd2);

    // Synchronous clear
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    checkValue("clr_stall_cnt", stall_cnt, 32'd0);
    checkValue("clr_flush_cnt", flush_cnt, 32'd0);

    // Back-to-back MUL/DIV with start held for two instructions
    for (int c = 1; c <= 13; c++) begin
      logic st;
      @(negedge clk);
      exe_md_start = (c <= 7);
      #1;
      st = (c <= 5) || (c >= 7 && c <= 11);
      checkOutput($sformatf("md_cyc%0d", c), st ? 4'b1110 : 4'b0000,
                  st ? 3'b001 : 3'b000, 1'b0, (c == 6) || (c == 12));
      if (c == 7) checkValue("md_stall_cnt", stall_cnt, 32'd5);
    end

    // dm_busy overlapping BUSY and DONE
    for (int c = 1; c <= 9; c++) begin
      logic [3:0] es;
      logic [2:0] ef;
      @(negedge clk);
      exe_md_start = (c == 1);
      dm_busy      = (c >= 3 && c <= 7);
      #1;
      if (c <= 2) begin es = 4'b1110; ef = 3'b001; end
      else if (c <= 7) begin es = 4'b1111; ef = 3'b000; end
      else begin es = 4'b0000; ef = 3'b000; end
      checkOutput($sformatf("dm_cyc%0d", c), es, ef, 1'b0, (c >= 6 && c <= 8));
    end

    // Reset asserted in the middle of BUSY
    @(negedge clk);
    clearInputs();
    exe_md_start = 1'b1;
    @(negedge clk);
    exe_md_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_busy_outputs", 4'b0000, 3'b000, 1'b0, 1'b0);
    checkValue("rst_busy_stall_cnt", stall_cnt, 32'd0);
    checkValue("rst_busy_flush_cnt", flush_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("post_rst%0d", c), 4'b0000, 3'b000, 1'b0, 1'b0);
    end

    // Saturation of stall_cnt, then clear overriding an increment
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    im_busy = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      #1;
      checkValue($sformatf("sat%0d", k), stall_cnt, (k == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
    end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    im_busy = 1'b0;
    #1;
    checkValue("sat_clr", stall_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage RISC-V core. It generates the per-stage Stall/Flush inputs of the IF→ID, ID→EXE and EXE→MEM stage registers. Sources are load-use hazards, branch mispredictions resolved in EXE against the predictor's BP_taken, instruction/data memory wait states and a multi-cycle MUL/DIV sequencer. It also keeps saturating stall/flush performance counters.

## Interface
- MD_LAT, 4: MUL/DIV busy cycles, legal range 1..255.
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
- exe_rd  in  5  destination index of the instruction in EXE.
- exe_is_load  in  1  EXE instruction is a load.
- exe_br_valid  in  1  EXE holds a branch/jump with a resolved outcome.
- exe_br_taken  in  1  actual outcome.
- exe_BP_taken  in  1  prediction carried through the EXE stage register.
- exe_md_start  in  1  EXE holds a MUL/DIV instruction.
- im_busy, dm_busy  in  1 each  instruction/data memory not ready this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- stall_if, stall_id, stall_exe, stall_mem  out  1 each  hold PC / stage register.
- flush_id, flush_exe, flush_mem  out  1 each  load bubble into stage register.
- pc_redirect  out  1  PC takes the EXE-computed target this cycle.
- md_done  out  1  MUL/DIV result valid in EXE this cycle.
- stall_cnt, flush_cnt  out  32 each  performance counters.

## Operation
- All stall/flush/redirect outputs are combinational from the inputs and the FSM state. Stage registers give Stall priority over Flush.
- mispredict = exe_br_valid & (exe_br_taken != exe_BP_taken).
- load_use = exe_is_load & exe_rd!=0 & ((id_use_rs1 & id_rs1==exe_rd) | (id_use_rs2 & id_rs2==exe_rd)).
- md_stall = (state==IDLE & exe_md_start) | state==BUSY.
- Priority, highest first; only the first matching rule drives the outputs:
  1. dm_busy: all four stall_* = 1, all flush_* = 0, pc_redirect = 0.
  2. mispredict: flush_id = flush_exe = 1 and pc_redirect = 1. All stalls are 0. This overrides load_use and im_busy.
  3. md_stall: stall_if = stall_id = stall_exe = 1 and flush_mem = 1.
  4. load_use: stall_if = stall_id = 1 and flush_exe = 1. Exactly one bubble.
  5. im_busy alone: stall_if = 1 and flush_id = 1.
- im_busy together with rule 3 or 4: stall_if is already 1 and flush_id stays 0.
- MUL/DIV FSM has three states: IDLE, BUSY, DONE. Counter md_cnt is 8 bits.
  - IDLE → BUSY when exe_md_start & !dm_busy & !mispredict; md_cnt ← MD_LAT-1.
  - BUSY: md_cnt decrements each cycle, including while dm_busy. At md_cnt==0 go to DONE.
  - DONE: md_done = 1 and no md_stall. Go to IDLE when !dm_busy; otherwise hold DONE.
  - DONE ignores exe_md_start, so a back-to-back MUL/DIV starts from IDLE on the following cycle.
- stall_cnt +1 on each cycle in which any stall_* is 1.
- flush_cnt +1 on each cycle in which mispredict wins priority.
- Both counters saturate at 32'hFFFF_FFFF. cnt_clr has priority over increment and clears to 0.

## Timing
- Reset (rst=0): state=IDLE, md_cnt=0, both counters 0. All outputs 0 except those combinationally implied by the inputs; with all inputs 0, every output is 0.
- Reset asserted mid-BUSY aborts to IDLE immediately. No md_done is produced.
- Zero-latency decisions: outputs respond in the same cycle as the inputs and take effect at the next clk edge.
- MUL/DIV timing, with no dm_busy:
  - The instruction occupies EXE for MD_LAT+2 cycles: 1 IDLE, MD_LAT BUSY, 1 DONE.
  - stall_exe is high for MD_LAT+1 cycles.
  - md_done is a 1-cycle pulse.
- dm_busy during BUSY does not extend the count. dm_busy during DONE holds md_done high until release.
- Counters update on the edge following the qualifying cycle and are visible one cycle later.
- load_use with exe_rd==0 never stalls. A load in EXE with dm_busy stalls under rule 1 only.

## Test plan
- Load-use: exe_is_load=1, exe_rd=5, id_rs1=5, id_use_rs1=1 → one cycle with stall_if=stall_id=flush_exe=1. With exe_rd=0 → all outputs 0.
- Mispredict vs hazard: exe_br_valid=1, exe_br_taken=1, exe_BP_taken=0, with load_use and im_busy also active → flush_id=flush_exe=pc_redirect=1 and all stalls 0. flush_cnt goes 0→1.
- MUL/DIV, MD_LAT=4: exe_md_start held high → stall_exe high for 5 cycles, md_done high on cycle 6, then a fresh start. stall_cnt increments by 5.
- dm_busy overlap: dm_busy asserted for 3 cycles while BUSY with md_cnt=2 → FSM reaches DONE on schedule. md_done stays high until dm_busy drops. All four stall_* are 1 during dm_busy.
- Reset/saturation: drop rst mid-BUSY → state IDLE, md_done never pulses, counters 0. Force stall_cnt to near-max via 1-cycle stalls with a long run → stall_cnt holds at FFFF_FFFF. cnt_clr=1 → 0 on the next edge.
